// File: rtl/ysyx_25040129_idu_q.sv
`default_nettype none
// ============================================================================
// ysyx_25040129_idu_q : RV32I/E decode stage feeding a DEPTH-entry micro-op FIFO
// Revision 1.0
// ============================================================================
module ysyx_25040129_idu_q #(
  parameter int DEPTH = 2,
  parameter bit RV32E = 1'b0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [31:0]             in_inst,
  input  logic [31:0]             in_pc,
  output logic [4:0]              rs1_addr,
  output logic [4:0]              rs2_addr,
  input  logic [31:0]             rs1_data,
  input  logic [31:0]             rs2_data,
  output logic [11:0]             csr_addr,
  input  logic [31:0]             csr_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [31:0]             out_pc,
  output logic [31:0]             out_src1,
  output logic [31:0]             out_src2,
  output logic [31:0]             out_imm,
  output logic [31:0]             out_wdata,
  output logic [4:0]              out_rd,
  output logic [3:0]              out_alu_op,
  output logic [2:0]              out_lsu_rd,
  output logic [1:0]              out_lsu_wr,
  output logic                    out_reg_wr,
  output logic                    out_csr_wr,
  output logic                    out_jump,
  output logic                    out_jalr,
  output logic                    out_ecall,
  output logic                    out_ebreak,
  output logic                    out_mret,
  output logic                    out_illegal,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0110;
  localparam logic [3:0] ALU_EQ  = 4'b1001;
  localparam logic [3:0] ALU_NE  = 4'b1010;
  localparam logic [3:0] ALU_LT  = 4'b1011;
  localparam logic [3:0] ALU_GE  = 4'b1100;
  localparam logic [3:0] ALU_LTU = 4'b1110;
  localparam logic [3:0] ALU_GEU = 4'b1111;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] src1;
    logic [31:0] src2;
    logic [31:0] imm;
    logic [31:0] wdata;
    logic [4:0]  rd;
    logic [3:0]  alu_op;
    logic [2:0]  lsu_rd;
    logic [1:0]  lsu_wr;
    logic        reg_wr;
    logic        csr_wr;
    logic        jump;
    logic        jalr;
    logic        ecall;
    logic        ebreak;
    logic        mret;
    logic        illegal;
  } uop_t;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [31:0] imm_i;
  logic [31:0] imm_s;
  logic [31:0] imm_b;
  logic [31:0] imm_u;
  logic [31:0] imm_j;
  logic        use_rs1;
  logic        use_rs2;
  logic        use_rd;
  logic        bad;
  uop_t        dec;

  assign opcode   = in_inst[6:0];
  assign funct3   = in_inst[14:12];
  assign rs1_addr = in_inst[19:15];
  assign rs2_addr = in_inst[24:20];
  assign csr_addr = in_inst[31:20];

  assign imm_i = {{20{in_inst[31]}}, in_inst[31:20]};
  assign imm_s = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
  assign imm_b = {{19{in_inst[31]}}, in_inst[31], in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0};
  assign imm_u = {in_inst[31:12], 12'b0};
  assign imm_j = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0};

  always_comb begin
    dec       = '0;
    dec.pc    = in_pc;
    dec.src1  = rs1_data;
    dec.src2  = rs2_data;
    dec.wdata = rs2_data;
    dec.imm   = imm_i;
    dec.rd    = in_inst[11:7];
    use_rs1   = 1'b0;
    use_rs2   = 1'b0;
    use_rd    = 1'b0;
    bad       = 1'b0;
    case (opcode)
      OPC_OP: begin
        dec.alu_op = {in_inst[30], funct3};
        dec.reg_wr = 1'b1;
        use_rs1 = 1'b1; use_rs2 = 1'b1; use_rd = 1'b1;
      end
      OPC_OPIMM: begin
        dec.alu_op = {(funct3 == 3'b101) ? in_inst[30] : 1'b0, funct3};
        dec.src2   = imm_i;
        dec.reg_wr = 1'b1;
        use_rs1 = 1'b1; use_rd = 1'b1;
      end
      OPC_LOAD: begin
        dec.src2   = imm_i;
        dec.reg_wr = 1'b1;
        use_rs1 = 1'b1; use_rd = 1'b1;
        case (funct3)
          3'b000:  dec.lsu_rd = 3'd1;
          3'b001:  dec.lsu_rd = 3'd2;
          3'b010:  dec.lsu_rd = 3'd3;
          3'b100:  dec.lsu_rd = 3'd4;
          3'b101:  dec.lsu_rd = 3'd5;
          default: bad = 1'b1;
        endcase
      end
      OPC_STORE: begin
        dec.imm  = imm_s;
        dec.src2 = imm_s;
        use_rs1 = 1'b1; use_rs2 = 1'b1;
        case (funct3)
          3'b000:  dec.lsu_wr = 2'd1;
          3'b001:  dec.lsu_wr = 2'd2;
          3'b010:  dec.lsu_wr = 2'd3;
          default: bad = 1'b1;
        endcase
      end
      OPC_BRANCH: begin
        dec.imm = imm_b;
        use_rs1 = 1'b1; use_rs2 = 1'b1;
        case (funct3)
          3'b000:  dec.alu_op = ALU_EQ;
          3'b001:  dec.alu_op = ALU_NE;
          3'b100:  dec.alu_op = ALU_LT;
          3'b101:  dec.alu_op = ALU_GE;
          3'b110:  dec.alu_op = ALU_LTU;
          3'b111:  dec.alu_op = ALU_GEU;
          default: bad = 1'b1;
        endcase
      end
      OPC_JAL: begin
        dec.imm  = imm_j;
        dec.src1 = in_pc;
        dec.src2 = imm_j;
        dec.jump = 1'b1; dec.jalr = 1'b1; dec.reg_wr = 1'b1;
        use_rd = 1'b1;
      end
      OPC_JALR: begin
        dec.src2 = imm_i;
        dec.jump = 1'b1; dec.jalr = 1'b1; dec.reg_wr = 1'b1;
        use_rs1 = 1'b1; use_rd = 1'b1;
      end
      OPC_LUI, OPC_AUIPC: begin
        dec.imm    = imm_u;
        dec.src1   = (opcode == OPC_AUIPC) ? in_pc : 32'd0;
        dec.src2   = imm_u;
        dec.reg_wr = 1'b1;
        use_rd = 1'b1;
      end
      OPC_SYSTEM: begin
        case (funct3)
          3'b000: begin
            case (in_inst[31:20])
              12'h000: dec.ecall  = 1'b1;
              12'h001: dec.ebreak = 1'b1;
              12'h302: dec.mret   = 1'b1;
              default: bad = 1'b1;
            endcase
          end
          // CSRRW: ALU passes rs1 through (src2 = 0) as the new CSR value
          3'b001: begin
            dec.src2   = 32'd0;
            dec.alu_op = ALU_ADD;
            dec.csr_wr = 1'b1;
            use_rs1 = 1'b1;
          end
          3'b010: begin
            dec.src2   = csr_data;
            dec.alu_op = ALU_OR;
            dec.reg_wr = 1'b1;
            use_rs1 = 1'b1; use_rd = 1'b1;
          end
          default: bad = 1'b1;
        endcase
      end
      default: bad = 1'b1;
    endcase
    if (RV32E && ((use_rs1 && in_inst[19]) || (use_rs2 && in_inst[24]) || (use_rd && in_inst[11])))
      bad = 1'b1;
    if (bad) begin
      dec.reg_wr  = 1'b0;
      dec.csr_wr  = 1'b0;
      dec.lsu_rd  = 3'd0;
      dec.lsu_wr  = 2'd0;
      dec.jump    = 1'b0;
      dec.jalr    = 1'b0;
      dec.ecall   = 1'b0;
      dec.ebreak  = 1'b0;
      dec.mret    = 1'b0;
      dec.illegal = 1'b1;
    end
  end

  uop_t          mem [DEPTH];
  uop_t          head;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic          enq;
  logic          deq;

  assign in_ready  = (count != CW'(DEPTH));
  assign out_valid = (count != '0);
  assign enq       = in_valid & in_ready;
  assign deq       = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (enq && !flush)
      mem[wr_ptr] <= dec;
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      if (enq) wr_ptr <= wr_ptr + PW'(1);
      if (deq) rd_ptr <= rd_ptr + PW'(1);
      case ({enq, deq})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign head        = mem[rd_ptr];
  assign out_pc      = head.pc;
  assign out_src1    = head.src1;
  assign out_src2    = head.src2;
  assign out_imm     = head.imm;
  assign out_wdata   = head.wdata;
  assign out_rd      = head.rd;
  assign out_alu_op  = head.alu_op;
  assign out_lsu_rd  = head.lsu_rd;
  assign out_lsu_wr  = head.lsu_wr;
  assign out_reg_wr  = head.reg_wr;
  assign out_csr_wr  = head.csr_wr;
  assign out_jump    = head.jump;
  assign out_jalr    = head.jalr;
  assign out_ecall   = head.ecall;
  assign out_ebreak  = head.ebreak;
  assign out_mret    = head.mret;
  assign out_illegal = head.illegal;

endmodule
`default_nettype wire

// File: tb/tb_ysyx_25040129_idu_q.sv
`default_nettype none
// ============================================================================
// tb_ysyx_25040129_idu_q : RV32I and RV32E instances against a queue-based model
// Revision 1.0
// ============================================================================
module tb_ysyx_25040129_idu_q;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready;
  logic [31:0] in_inst, in_pc, rs1_data, rs2_data, csr_data;

  logic        rdy_d  [2];
  logic [4:0]  rs1a_d [2];
  logic [4:0]  rs2a_d [2];
  logic [11:0] csra_d [2];
  logic        ov_d   [2];
  logic [31:0] pc_d   [2];
  logic [31:0] s1_d   [2];
  logic [31:0] s2_d   [2];
  logic [31:0] imm_d  [2];
  logic [31:0] wd_d   [2];
  logic [4:0]  rd_d   [2];
  logic [3:0]  alu_d  [2];
  logic [2:0]  lr_d   [2];
  logic [1:0]  lw_d   [2];
  logic        regw_d [2];
  logic        csrw_d [2];
  logic        jmp_d  [2];
  logic        jr_d   [2];
  logic        ec_d   [2];
  logic        eb_d   [2];
  logic        mr_d   [2];
  logic        ill_d  [2];
  logic [1:0]  cnt_d  [2];

  always #5 clk = ~clk;

  // Instance 0 decodes RV32I, instance 1 RV32E; both see identical stimulus.
  for (genvar g = 0; g < 2; g++) begin : g_dut
    ysyx_25040129_idu_q #(.DEPTH(DEPTH), .RV32E(g == 1)) u_dut (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(rdy_d[g]), .in_inst(in_inst), .in_pc(in_pc),
      .rs1_addr(rs1a_d[g]), .rs2_addr(rs2a_d[g]),
      .rs1_data(rs1_data), .rs2_data(rs2_data),
      .csr_addr(csra_d[g]), .csr_data(csr_data),
      .out_valid(ov_d[g]), .out_ready(out_ready),
      .out_pc(pc_d[g]), .out_src1(s1_d[g]), .out_src2(s2_d[g]), .out_imm(imm_d[g]),
      .out_wdata(wd_d[g]), .out_rd(rd_d[g]), .out_alu_op(alu_d[g]),
      .out_lsu_rd(lr_d[g]), .out_lsu_wr(lw_d[g]),
      .out_reg_wr(regw_d[g]), .out_csr_wr(csrw_d[g]), .out_jump(jmp_d[g]), .out_jalr(jr_d[g]),
      .out_ecall(ec_d[g]), .out_ebreak(eb_d[g]), .out_mret(mr_d[g]), .out_illegal(ill_d[g]),
      .count(cnt_d[g])
    );
  end

  int n_assert = 0;
  int n_fail   = 0;

  logic [181:0] q0[$], m0[$], q1[$], m1[$];
  logic [31:0]  last_rs2, last_csr;

  task automatic chk(input string tag, input logic [181:0] o, input logic [181:0] e);
    n_assert++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  function automatic logic [181:0] obs(input int g);
    return {pc_d[g], s1_d[g], s2_d[g], imm_d[g], wd_d[g], rd_d[g], alu_d[g], lr_d[g], lw_d[g],
            regw_d[g], csrw_d[g], jmp_d[g], jr_d[g], ec_d[g], eb_d[g], mr_d[g], ill_d[g]};
  endfunction

  // Reference decode straight from the ISA rules; mask bits select the fields that are defined.
  function automatic void ref_dec(input logic [31:0] i, input logic [31:0] pc, input logic [31:0] r1,
                                  input logic [31:0] r2, input logic [31:0] cs, input bit e,
                                  output logic [181:0] ex, output logic [181:0] mk);
    logic [31:0] s1, s2, imm, ii, is, ib, iu, ij;
    logic [3:0]  alu;
    logic [2:0]  lr;
    logic [1:0]  lw;
    bit regw, csrw, jmp, jr, ec, eb, mr, ill, u1, u2, ud;
    bit ms1, ms2, mim, mrd, mal, mcw, mwd;
    ii = {{20{i[31]}}, i[31:20]};
    is = {{20{i[31]}}, i[31:25], i[11:7]};
    ib = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
    iu = {i[31:12], 12'b0};
    ij = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
    s1 = r1; s2 = r2; imm = 32'd0; alu = 4'd0; lr = 3'd0; lw = 2'd0;
    {regw, csrw, jmp, jr, ec, eb, mr, ill, u1, u2, ud} = '0;
    {ms1, ms2, mrd, mal, mcw, mwd} = 6'b111111; mim = 1'b0;
    case (i[6:0])
      7'h33: begin alu = {i[30], i[14:12]}; regw = 1; u1 = 1; u2 = 1; ud = 1; end
      7'h13: begin
        alu = {(i[14:12] == 3'd5) ? i[30] : 1'b0, i[14:12]};
        s2 = ii; imm = ii; mim = 1; regw = 1; u1 = 1; ud = 1;
      end
      7'h03: begin
        s2 = ii; imm = ii; mim = 1; regw = 1; u1 = 1; ud = 1;
        case (i[14:12])
          3'd0: lr = 3'd1; 3'd1: lr = 3'd2; 3'd2: lr = 3'd3; 3'd4: lr = 3'd4; 3'd5: lr = 3'd5;
          default: ill = 1;
        endcase
      end
      7'h23: begin
        s2 = is; imm = is; mim = 1; mrd = 0; u1 = 1; u2 = 1;
        if (i[14:12] < 3'd3) lw = i[13:12] + 2'd1; else ill = 1;
      end
      7'h63: begin
        imm = ib; mim = 1; mrd = 0; u1 = 1; u2 = 1;
        case (i[14:12])
          3'd0: alu = 4'b1001; 3'd1: alu = 4'b1010; 3'd4: alu = 4'b1011;
          3'd5: alu = 4'b1100; 3'd6: alu = 4'b1110; 3'd7: alu = 4'b1111;
          default: ill = 1;
        endcase
      end
      7'h6F: begin s1 = pc; s2 = ij; imm = ij; mim = 1; jmp = 1; jr = 1; regw = 1; ud = 1; end
      7'h67: begin s2 = ii; imm = ii; mim = 1; jmp = 1; jr = 1; regw = 1; u1 = 1; ud = 1; end
      7'h37: begin s1 = 32'd0; s2 = iu; imm = iu; mim = 1; regw = 1; ud = 1; end
      7'h17: begin s1 = pc; s2 = iu; imm = iu; mim = 1; regw = 1; ud = 1; end
      7'h73: begin
        if (i[14:12] == 3'd1) begin
          s2 = 32'd0; csrw = 1; u1 = 1;
        end else if (i[14:12] == 3'd2) begin
          s2 = cs; alu = 4'b0110; regw = 1; mcw = 0; u1 = 1; ud = 1;
        end else if (i[14:12] == 3'd0) begin
          ms1 = 0; ms2 = 0; mal = 0; mrd = 0;
          if (i[31:20] == 12'h000) ec = 1;
          else if (i[31:20] == 12'h001) eb = 1;
          else if (i[31:20] == 12'h302) mr = 1;
          else ill = 1;
        end else ill = 1;
      end
      default: ill = 1;
    endcase
    if (e && ((u1 && i[19]) || (u2 && i[24]) || (ud && i[11]))) ill = 1;
    if (ill) begin
      {regw, csrw, jmp, jr, ec, eb, mr} = '0; lr = 3'd0; lw = 2'd0;
      {ms1, ms2, mim, mrd, mal, mwd} = '0; mcw = 1;
    end
    ex = {pc, s1, s2, imm, r2, i[11:7], alu, lr, lw, regw, csrw, jmp, jr, ec, eb, mr, ill};
    mk = {{32{1'b1}}, {32{ms1}}, {32{ms2}}, {32{mim}}, {32{mwd}}, {5{mrd}}, {4{mal}},
          3'b111, 2'b11, 1'b1, mcw, 6'b111111};
  endfunction

  task automatic state_chk(input int g, input int sz, input logic [181:0] he, input logic [181:0] hm);
    chk($sformatf("count[%0d]", g), 182'(cnt_d[g]), 182'(sz));
    chk($sformatf("out_valid[%0d]", g), 182'(ov_d[g]), 182'(sz != 0));
    chk($sformatf("in_ready[%0d]", g), 182'(rdy_d[g]), 182'(sz != DEPTH));
    if (sz != 0) chk($sformatf("head[%0d]", g), obs(g) & hm, he & hm);
  endtask

  // One clock: drive at negedge, check, let the edge happen, advance the model.
  task automatic step(input logic v, input logic [31:0] inst, input logic [31:0] pc,
                      input logic ordy, input logic fl);
    logic [181:0] e0, k0, e1, k1;
    bit enq, deq;
    in_valid = v; in_inst = inst; in_pc = pc; out_ready = ordy; flush = fl;
    rs1_data = $urandom; rs2_data = $urandom; csr_data = $urandom;
    #1;
    for (int g = 0; g < 2; g++) begin
      chk($sformatf("rs1_addr[%0d]", g), 182'(rs1a_d[g]), 182'(inst[19:15]));
      chk($sformatf("rs2_addr[%0d]", g), 182'(rs2a_d[g]), 182'(inst[24:20]));
      chk($sformatf("csr_addr[%0d]", g), 182'(csra_d[g]), 182'(inst[31:20]));
    end
    state_chk(0, q0.size(), (q0.size() != 0) ? q0[0] : '0, (m0.size() != 0) ? m0[0] : '0);
    state_chk(1, q1.size(), (q1.size() != 0) ? q1[0] : '0, (m1.size() != 0) ? m1[0] : '0);
    enq = v && (q0.size() != DEPTH);
    deq = ordy && (q0.size() != 0);
    ref_dec(inst, pc, rs1_data, rs2_data, csr_data, 1'b0, e0, k0);
    ref_dec(inst, pc, rs1_data, rs2_data, csr_data, 1'b1, e1, k1);
    last_rs2 = rs2_data; last_csr = csr_data;
    @(posedge clk);
    if (deq) begin
      void'(q0.pop_front()); void'(m0.pop_front());
      void'(q1.pop_front()); void'(m1.pop_front());
    end
    if (fl) begin
      q0.delete(); m0.delete(); q1.delete(); m1.delete();
    end else if (enq) begin
      q0.push_back(e0); m0.push_back(k0); q1.push_back(e1); m1.push_back(k1);
    end
    @(negedge clk);
  endtask

  function automatic logic [31:0] rnd_inst();
    logic [31:0] w;
    int k;
    w = $urandom;
    k = $urandom_range(0, 11);
    case (k)
      0: w[6:0] = 7'h33;  1: w[6:0] = 7'h13;  2: w[6:0] = 7'h03;  3: w[6:0] = 7'h23;
      4: w[6:0] = 7'h63;  5: w[6:0] = 7'h6F;  6: w[6:0] = 7'h67;  7: w[6:0] = 7'h37;
      8: w[6:0] = 7'h17;  9: w[6:0] = 7'h73;
      10: begin
        w[6:0] = 7'h73; w[14:12] = 3'b000;
        case ($urandom_range(0, 3))
          0: w[31:20] = 12'h000;
          1: w[31:20] = 12'h001;
          2: w[31:20] = 12'h302;
          default: ;
        endcase
      end
      default: ;
    endcase
    if ($urandom_range(0, 1) == 1) begin w[24] = 1'b0; w[19] = 1'b0; w[11] = 1'b0; end
    return w;
  endfunction

  logic [31:0] pcr;

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_inst = 32'd0; in_pc = 32'd0; rs1_data = 32'd0; rs2_data = 32'd0; csr_data = 32'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int g = 0; g < 2; g++) begin
      chk("reset_count", 182'(cnt_d[g]), 182'(2'd0));
      chk("reset_out_valid", 182'(ov_d[g]), 182'(1'b0));
      chk("reset_in_ready", 182'(rdy_d[g]), 182'(1'b1));
    end

    // addi x1,x0,5
    step(1'b1, 32'h00500093, 32'h0000_1000, 1'b0, 1'b0);
    chk("addi_out_valid", 182'(ov_d[0]), 182'(1'b1));
    chk("addi_src2", 182'(s2_d[0]), 182'(32'd5));
    chk("addi_rd", 182'(rd_d[0]), 182'(5'd1));
    chk("addi_alu_op", 182'(alu_d[0]), 182'(4'b0000));
    chk("addi_reg_wr", 182'(regw_d[0]), 182'(1'b1));
    chk("addi_count", 182'(cnt_d[0]), 182'(2'd1));

    // bge x1,x2,+8 fills the queue
    step(1'b1, 32'h0020D463, 32'h0000_1004, 1'b0, 1'b0);
    chk("full_count", 182'(cnt_d[0]), 182'(2'd2));
    chk("full_in_ready", 182'(rdy_d[0]), 182'(1'b0));
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    chk("pop_count", 182'(cnt_d[0]), 182'(2'd1));
    chk("pop_in_ready", 182'(rdy_d[0]), 182'(1'b1));
    chk("bge_pc", 182'(pc_d[0]), 182'(32'h0000_1004));
    chk("bge_alu_op", 182'(alu_d[0]), 182'(4'b1100));
    chk("bge_imm", 182'(imm_d[0]), 182'(32'd8));

    // sw x1,4(x2) streamed with simultaneous enq+deq
    for (int k = 0; k < 10; k++) begin
      step(1'b1, 32'h00112223, 32'h0000_2000 + 32'(4 * k), 1'b1, 1'b0);
      chk("stream_count", 182'(cnt_d[0]), 182'(2'd1));
      if (k == 0) begin
        chk("sw_lsu_wr", 182'(lw_d[0]), 182'(2'd3));
        chk("sw_imm", 182'(imm_d[0]), 182'(32'd4));
        chk("sw_wdata", 182'(wd_d[0]), 182'(last_rs2));
      end
    end

    // flush at count 2 with in_valid, then at count 1 where the enq would otherwise land
    step(1'b1, 32'h00500093, 32'h0000_3000, 1'b0, 1'b0);
    step(1'b1, 32'h00500093, 32'h0000_BAD0, 1'b0, 1'b1);
    chk("flush_count", 182'(cnt_d[0]), 182'(2'd0));
    chk("flush_out_valid", 182'(ov_d[0]), 182'(1'b0));
    step(1'b1, 32'h00500093, 32'h0000_3100, 1'b0, 1'b0);
    step(1'b1, 32'h00500093, 32'h0000_BAD4, 1'b0, 1'b1);
    chk("flush_drop_count", 182'(cnt_d[0]), 182'(2'd0));

    // illegal encodings
    step(1'b1, 32'hFFFF_FFFF, 32'h0000_4000, 1'b0, 1'b0);
    chk("ones_illegal", 182'(ill_d[0]), 182'(1'b1));
    chk("ones_reg_wr", 182'(regw_d[0]), 182'(1'b0));
    step(1'b1, 32'h00208A33, 32'h0000_4004, 1'b1, 1'b0);
    chk("x20_illegal_e", 182'(ill_d[1]), 182'(1'b1));
    chk("x20_reg_wr_e", 182'(regw_d[1]), 182'(1'b0));
    chk("x20_legal_i", 182'(ill_d[0]), 182'(1'b0));
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // csrrs x5,mstatus,x0
    step(1'b1, 32'h300022F3, 32'h0000_5000, 1'b0, 1'b0);
    chk("csrrs_src2", 182'(s2_d[0]), 182'(last_csr));
    chk("csrrs_alu_op", 182'(alu_d[0]), 182'(4'b0110));
    chk("csrrs_rd", 182'(rd_d[0]), 182'(5'd5));
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // random traffic against the model
    pcr = 32'h0001_0000;
    for (int k = 0; k < 600; k++) begin
      step($urandom_range(0, 3) != 0, rnd_inst(), pcr, $urandom_range(0, 4) < 3,
           $urandom_range(0, 31) == 0);
      pcr = pcr + 32'd4;
    end
    for (int k = 0; k < 4; k++) step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
